cmac_pe_param: RTL
==================

CMAC_PE_PARAM -- requirements
Module: cmac_pe_param

Interface
REQ-001 The block SHALL have these parameters: W_WIDTH, 8, weight width.
REQ-002 The block SHALL have these parameters: A_WIDTH, 8, activation width.
REQ-003 The block SHALL have these parameters: PSUM_WIDTH, 24, partial-sum width; PSUM_WIDTH >= W_WIDTH+A_WIDTH.
REQ-004 The block SHALL have these parameters: ERR_CNT_WIDTH, 16, lifetime error counter width.
REQ-005 The block SHALL have these parameters: WINDOW, 256, valid cycles per error-rate window, >= 2.
REQ-006 The block SHALL have these parameters: ERR_THRESH, 4, window error count that raises err_alarm.
REQ-007 The block SHALL have one clock and a synchronous active-high reset, with ports in this order: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-008 The block SHALL have these data ports: weight_in in W_WIDTH; weight_load in 1; act_in in A_WIDTH; act_valid_in in 1; psum_in in PSUM_WIDTH; psum_shadow_in in PSUM_WIDTH, late-sampled copy of psum_in.
REQ-009 The block SHALL have these data ports: err_prod_in in M=W_WIDTH+A_WIDTH, upstream compensation product; comp_en in 1; err_count_clr in 1.
REQ-010 The block SHALL have these outputs: act_out A_WIDTH; act_valid_out 1; psum_out PSUM_WIDTH; psum_valid_out 1; err_prod_out M; error_out 1; err_count ERR_CNT_WIDTH; err_alarm 1.

Function
REQ-011 The block SHALL load weight_reg from weight_in on any edge with weight_load=1; the weight loaded at that edge applies to the activation sampled at the same edge.
REQ-012 Stage 1 SHALL register act_in, act_valid_in, psum_in, psum_shadow_in and err_prod_in every edge; act_out/act_valid_out SHALL be driven from these registers (1-cycle forward latency).
REQ-013 The block SHALL compute product = weight_reg*act_s1, unsigned, M bits, zero-extended to PSUM_WIDTH.
REQ-014 err_s1 SHALL be 1 iff valid_s1 and comp_en and psum_s1 != shadow_s1.
REQ-015 Stage 2 SHALL register outputs: on valid_s1 with err_s1=0, psum_out = psum_s1 + err_prod_s1 + product (mod 2^PSUM_WIDTH), err_prod_out = 0.
REQ-016 On err_s1=1, stage 2 SHALL set psum_out = shadow_s1 + err_prod_s1 (mod 2^PSUM_WIDTH) and err_prod_out = product, so the downstream PE adds this PE's dropped product.
REQ-017 psum_valid_out and error_out SHALL equal valid_s1 and err_s1 delayed one cycle (2-cycle input-to-psum latency).
REQ-018 On valid_s1=0, psum_out and err_prod_out SHALL hold their previous values and error_out SHALL be 0.
REQ-019 With comp_en=0, the block SHALL never flag an error, shall leave the counters unchanged, and psum_shadow_in SHALL be ignored.
REQ-020 err_count SHALL increment on each err_s1=1 edge, saturate at all-ones, and go to 0 on err_count_clr; clear SHALL win over a simultaneous error.
REQ-021 The block SHALL count valid_s1 cycles from 0 to WINDOW-1 in a window counter and count errors in the window in win_errs.
REQ-022 On the last valid cycle of a window, err_alarm SHALL load (win_errs + err_s1 >= ERR_THRESH), and the window counter and win_errs SHALL both reset to 0.
REQ-023 err_alarm SHALL hold between window ends; err_count_clr SHALL NOT affect the window logic.

Reset
REQ-024 While rst=1 at an edge, all registers, including weight_reg, pipeline data/valid, counters and err_alarm, SHALL go to 0; rst SHALL override all other inputs.
REQ-025 Reset mid-operation SHALL discard in-flight data: psum_valid_out=0 on the first edge after rst deasserts, unless new valid data arrives.

Verification
REQ-026 No-error path: weight 3, act 5, psum_in = shadow = 100, err_prod_in 7, comp_en 1 -> two edges later: psum_out 122, err_prod_out 0, error_out 0, psum_valid_out 1.
REQ-027 Error path: same inputs but shadow 96 -> psum_out 103, err_prod_out 15, error_out 1, err_count 1.
REQ-028 comp_en=0 with psum 100, shadow 96 -> psum_out 122, error_out 0, err_count unchanged.
REQ-029 Wrap: psum_in = shadow = 0xFFFFF0, product 15, err_prod_in 2 -> psum_out 0x000001.
REQ-030 Parameters WINDOW=8, ERR_THRESH=2, ERR_CNT_WIDTH=2: 5 errors in 8 valid cycles -> err_alarm 1 after the 8th valid cycle, err_count 3 (saturated); err_count_clr on a concurrent error -> 0.
REQ-031 rst asserted one cycle after a valid input -> psum_valid_out 0, all outputs 0, err_alarm 0.

Source files
------------

// File: rtl/cmac_pe_param.sv
// Weight-stationary MAC processing element with shadow-sample error detection.
// A detected psum error forwards this PE's product downstream; a windowed error rate drives err_alarm.
module cmac_pe_param #(
   parameter int W_WIDTH       = 8,
   parameter int A_WIDTH       = 8,
   parameter int PSUM_WIDTH    = 24,
   parameter int ERR_CNT_WIDTH = 16,
   parameter int WINDOW        = 256,
   parameter int ERR_THRESH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [W_WIDTH-1:0]           weight_in,
   input  logic                         weight_load,
   input  logic [A_WIDTH-1:0]           act_in,
   input  logic                         act_valid_in,
   input  logic [PSUM_WIDTH-1:0]        psum_in,
   input  logic [PSUM_WIDTH-1:0]        psum_shadow_in,
   input  logic [W_WIDTH+A_WIDTH-1:0]   err_prod_in,
   input  logic                         comp_en,
   input  logic                         err_count_clr,
   output logic [A_WIDTH-1:0]           act_out,
   output logic                         act_valid_out,
   output logic [PSUM_WIDTH-1:0]        psum_out,
   output logic                         psum_valid_out,
   output logic [W_WIDTH+A_WIDTH-1:0]   err_prod_out,
   output logic                         error_out,
   output logic [ERR_CNT_WIDTH-1:0]     err_count,
   output logic                         err_alarm
);

   localparam int M             = W_WIDTH + A_WIDTH;
   localparam int WIN_CNT_WIDTH = $clog2(WINDOW);
   localparam int WIN_ERR_WIDTH = $clog2(WINDOW + 1);

   logic [W_WIDTH-1:0]        weight_reg;
   logic [A_WIDTH-1:0]        act_s1_reg;
   logic                      valid_s1_reg;
   logic [PSUM_WIDTH-1:0]     psum_s1_reg;
   logic [PSUM_WIDTH-1:0]     shadow_s1_reg;
   logic [M-1:0]              err_prod_s1_reg;

   logic [PSUM_WIDTH-1:0]     psum_out_reg;
   logic [M-1:0]              err_prod_out_reg;
   logic                      psum_valid_reg;
   logic                      error_reg;
   logic [ERR_CNT_WIDTH-1:0]  err_count_reg;
   logic [WIN_CNT_WIDTH-1:0]  win_cnt_reg;
   logic [WIN_ERR_WIDTH-1:0]  win_errs_reg;
   logic                      err_alarm_reg;

   logic [M-1:0]              product;
   logic [PSUM_WIDTH-1:0]     product_ext;
   logic [PSUM_WIDTH-1:0]     err_prod_ext;
   logic                      err_s1;
   logic [PSUM_WIDTH-1:0]     psum_ok_next;
   logic [PSUM_WIDTH-1:0]     psum_err_next;
   logic                      win_last;
   logic [WIN_ERR_WIDTH-1:0]  win_errs_inc;
   logic                      alarm_hit;

   assign product       = M'(weight_reg) * M'(act_s1_reg);
   assign product_ext   = PSUM_WIDTH'(product);
   assign err_prod_ext  = PSUM_WIDTH'(err_prod_s1_reg);

   // The shadow copy is only trusted while compensation is enabled.
   assign err_s1        = valid_s1_reg & comp_en & (psum_s1_reg != shadow_s1_reg);

   assign psum_ok_next  = psum_s1_reg + err_prod_ext + product_ext;
   assign psum_err_next = shadow_s1_reg + err_prod_ext;

   assign win_last      = valid_s1_reg && (win_cnt_reg == WIN_CNT_WIDTH'(WINDOW - 1));
   assign win_errs_inc  = win_errs_reg + WIN_ERR_WIDTH'(err_s1);
   assign alarm_hit     = (int'(win_errs_inc) >= ERR_THRESH);

   // Stage 1: weight and input capture
   always_ff @(posedge clk) begin
      if (rst) begin
         weight_reg      <= '0;
         act_s1_reg      <= '0;
         valid_s1_reg    <= 1'b0;
         psum_s1_reg     <= '0;
         shadow_s1_reg   <= '0;
         err_prod_s1_reg <= '0;
      end else begin
         if (weight_load) begin
            weight_reg <= weight_in;
         end
         act_s1_reg      <= act_in;
         valid_s1_reg    <= act_valid_in;
         psum_s1_reg     <= psum_in;
         shadow_s1_reg   <= psum_shadow_in;
         err_prod_s1_reg <= err_prod_in;
      end
   end

   // Stage 2: accumulate, or on error pass the shadow and hand our product downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         psum_out_reg     <= '0;
         err_prod_out_reg <= '0;
         psum_valid_reg   <= 1'b0;
         error_reg        <= 1'b0;
      end else begin
         psum_valid_reg <= valid_s1_reg;
         error_reg      <= err_s1;
         if (valid_s1_reg) begin
            if (err_s1) begin
               psum_out_reg     <= psum_err_next;
               err_prod_out_reg <= product;
            end else begin
               psum_out_reg     <= psum_ok_next;
               err_prod_out_reg <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_reg <= '0;
      end else if (err_count_clr) begin
         err_count_reg <= '0;
      end else if (err_s1 && (err_count_reg != {ERR_CNT_WIDTH{1'b1}})) begin
         err_count_reg <= err_count_reg + 1'b1;
      end
   end

   // Error-rate window; the lifetime clear deliberately leaves it alone
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt_reg   <= '0;
         win_errs_reg  <= '0;
         err_alarm_reg <= 1'b0;
      end else if (win_last) begin
         win_cnt_reg   <= '0;
         win_errs_reg  <= '0;
         err_alarm_reg <= alarm_hit;
      end else if (valid_s1_reg) begin
         win_cnt_reg  <= win_cnt_reg + 1'b1;
         win_errs_reg <= win_errs_inc;
      end
   end

   assign act_out        = act_s1_reg;
   assign act_valid_out  = valid_s1_reg;
   assign psum_out       = psum_out_reg;
   assign psum_valid_out = psum_valid_reg;
   assign err_prod_out   = err_prod_out_reg;
   assign error_out      = error_reg;
   assign err_count      = err_count_reg;
   assign err_alarm      = err_alarm_reg;

endmodule
